// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the N-rail power sequencer.
//   - State codes as seen on oState (debug visibility, fixed encoding).
//   - Default delay constants, in 1 ms ticks.
package pwr_seq_pkg;

  // oState codes
  localparam logic [3:0] StateOn    = 4'h0;
  localparam logic [3:0] StatePwrUp = 4'h1;
  localparam logic [3:0] StatePwrDn = 4'h2;
  localparam logic [3:0] StateIdle  = 4'h9;
  localparam logic [3:0] StateLeak  = 4'hE;
  localparam logic [3:0] StateFault = 4'hF;

  typedef enum logic [3:0] {
    StOn    = StateOn,
    StPwrUp = StatePwrUp,
    StPwrDn = StatePwrDn,
    StIdle  = StateIdle,
    StLeak  = StateLeak,
    StFault = StateFault
  } state_e;

  // Default delays (ticks of iTick_1ms)
  localparam int unsigned DefNumRails  = 4;
  localparam int unsigned DefTmrW      = 16;
  localparam int unsigned DefPgTimeout = 10000;
  localparam int unsigned DefOnDly     = 10;
  localparam int unsigned DefOffDly    = 10;

endpackage

// File: rtl/seq_tick_timer.sv
// Tick-driven delay timer shared by every sequencing step.
//   iClk      - clock
//   iRst_n    - asynchronous active-low reset
//   tick_i    - count enable strobe (1 ms)
//   clr_i     - synchronous clear, wins over tick_i
//   cmp_i     - compare value
//   expired_o - count >= cmp_i (a compare of 0 is expired straight after a clear)
module seq_tick_timer #(
  parameter int unsigned TMR_W = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             tick_i,
  input  logic             clr_i,
  input  logic [TMR_W-1:0] cmp_i,
  output logic             expired_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '1)) begin
      // Saturate at all-ones rather than wrap
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= cmp_i);

endmodule

// File: rtl/pwr_seq_nrail.sv
// Parametrised N-rail power sequencer.
// Rails come up in index order 0..N-1, each step gated by that rail's power-good being
// stable for ON_DLY ticks; power-down runs in reverse with OFF_DLY ticks between rails.
// Sequencing timeouts and runtime PG loss are captured per rail as sticky flags.
// A leak forces the LEAK_KEEP_MASK rail subset on until reset.
// Ports:
//   iClk, iRst_n  - clock, asynchronous active-low reset
//   iTick_1ms     - one-cycle 1 kHz strobe, time base for all delays
//   iPwr_Req      - power-on request level
//   iLeak_N       - leak detect, active low, asynchronous
//   iRail_Mask    - per-rail PG bypass
//   iPG           - per-rail power-good, asynchronous
//   iFault_Clr    - clears FAULT when no power request is pending
//   oRail_EN      - rail enables
//   oSeqFlt       - sticky power-up timeout flags
//   oRunFlt       - sticky runtime PG-loss flags
//   oState        - FSM state code
//   oPwr_Ok       - high only in ON
module pwr_seq_nrail
  import pwr_seq_pkg::*;
#(
  parameter int unsigned           NUM_RAILS      = DefNumRails,
  parameter int unsigned           TMR_W          = DefTmrW,
  parameter int unsigned           PG_TIMEOUT     = DefPgTimeout,
  parameter int unsigned           ON_DLY         = DefOnDly,
  parameter int unsigned           OFF_DLY        = DefOffDly,
  parameter logic [NUM_RAILS-1:0]  LEAK_KEEP_MASK = NUM_RAILS'(1)
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iTick_1ms,
  input  logic                 iPwr_Req,
  input  logic                 iLeak_N,
  input  logic [NUM_RAILS-1:0] iRail_Mask,
  input  logic [NUM_RAILS-1:0] iPG,
  input  logic                 iFault_Clr,
  output logic [NUM_RAILS-1:0] oRail_EN,
  output logic [NUM_RAILS-1:0] oSeqFlt,
  output logic [NUM_RAILS-1:0] oRunFlt,
  output logic [3:0]           oState,
  output logic                 oPwr_Ok
);

  localparam int unsigned IdxW = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
  localparam logic [IdxW-1:0]  LastIdx      = IdxW'(NUM_RAILS - 1);
  localparam logic [TMR_W-1:0] PgTimeoutCmp = TMR_W'(PG_TIMEOUT);
  localparam logic [TMR_W-1:0] OnDlyCmp     = TMR_W'(ON_DLY);
  localparam logic [TMR_W-1:0] OffDlyCmp    = TMR_W'(OFF_DLY);

  // Input synchronisers
  logic [NUM_RAILS-1:0] pg_meta_q, pg_sync_q;
  logic                 leak_meta_q, leak_sync_q;

  // FSM state
  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [NUM_RAILS-1:0] en_q, en_d;
  logic [NUM_RAILS-1:0] seq_flt_q, seq_flt_d;
  logic [NUM_RAILS-1:0] run_flt_q, run_flt_d;
  logic                 stable_q, stable_d;   // PWRUP: counting PG-stable rather than timeout
  logic                 dn_flt_q, dn_flt_d;   // PWRDN exit target: 1 = FAULT, 0 = IDLE
  logic                 pwr_ok_q, pwr_ok_d;

  // Timer control
  logic                 phase_clr;
  logic                 tmr_clr;
  logic [TMR_W-1:0]     tmr_cmp;
  logic                 tmr_exp;

  logic                 pg_ok;
  logic                 seq_to;
  logic [NUM_RAILS-1:0] run_lost;
  logic [IdxW-1:0]      idx_nxt, idx_prv;

  assign idx_nxt = idx_q + IdxW'(1);
  assign idx_prv = idx_q - IdxW'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    en_d      = en_q;
    seq_flt_d = seq_flt_q;
    run_flt_d = run_flt_q;
    stable_d  = stable_q;
    dn_flt_d  = dn_flt_q;
    phase_clr = 1'b0;
    tmr_cmp   = '0;
    pg_ok     = pg_sync_q[idx_q] | iRail_Mask[idx_q];
    seq_to    = 1'b0;
    run_lost  = en_q & ~iRail_Mask & ~pg_sync_q;

    if (!leak_sync_q) begin
      // Leak overrides everything, no sequencing
      state_d = StLeak;
      en_d    = LEAK_KEEP_MASK;
    end else begin
      case (state_q)
        StIdle: begin
          en_d  = '0;
          idx_d = '0;
          if (iPwr_Req) begin
            state_d  = StPwrUp;
            en_d[0]  = 1'b1;
            stable_d = 1'b0;
          end
        end

        StPwrUp: begin
          tmr_cmp = stable_q ? OnDlyCmp : PgTimeoutCmp;
          seq_to  = !pg_ok && !stable_q && tmr_exp;
          if (seq_to) begin
            seq_flt_d[idx_q] = 1'b1;
            en_d[idx_q]      = 1'b0;
            state_d          = StPwrDn;
            dn_flt_d         = 1'b1;
          end else if (!iPwr_Req) begin
            en_d[idx_q] = 1'b0;
            state_d     = StPwrDn;
            dn_flt_d    = 1'b0;
          end else if (pg_ok != stable_q) begin
            // PG edge: restart the timer in the other phase. A PG glitch therefore also
            // restarts the timeout window.
            stable_d  = pg_ok;
            phase_clr = 1'b1;
          end else if (stable_q && tmr_exp) begin
            stable_d = 1'b0;
            if (idx_q == LastIdx) begin
              state_d = StOn;
            end else begin
              idx_d         = idx_nxt;
              en_d[idx_nxt] = 1'b1;
            end
          end
        end

        StOn: begin
          if (|run_lost) begin
            run_flt_d     = run_flt_q | run_lost;
            state_d       = StPwrDn;
            idx_d         = LastIdx;
            en_d[LastIdx] = 1'b0;
            dn_flt_d      = 1'b1;
          end else if (!iPwr_Req) begin
            state_d       = StPwrDn;
            idx_d         = LastIdx;
            en_d[LastIdx] = 1'b0;
            dn_flt_d      = 1'b0;
          end
        end

        StPwrDn: begin
          tmr_cmp     = OffDlyCmp;
          en_d[idx_q] = 1'b0;
          if (tmr_exp) begin
            if (idx_q == '0) begin
              state_d = dn_flt_q ? StFault : StIdle;
              en_d    = '0;
            end else begin
              idx_d         = idx_prv;
              en_d[idx_prv] = 1'b0;
            end
          end
        end

        StFault: begin
          en_d = '0;
          if (iFault_Clr && !iPwr_Req) begin
            state_d   = StIdle;
            seq_flt_d = '0;
            run_flt_d = '0;
          end
        end

        StLeak: begin
          en_d = LEAK_KEEP_MASK;
        end

        default: begin
          state_d = StIdle;
          en_d    = '0;
          idx_d   = '0;
        end
      endcase
    end

    pwr_ok_d = (state_d == StOn);
  end

  assign tmr_clr = phase_clr || (state_d != state_q) || (idx_d != idx_q);

  seq_tick_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .tick_i    (iTick_1ms),
    .clr_i     (tmr_clr),
    .cmp_i     (tmr_cmp),
    .expired_o (tmr_exp)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pg_meta_q   <= '0;
      pg_sync_q   <= '0;
      leak_meta_q <= 1'b1;
      leak_sync_q <= 1'b1;
      state_q     <= StIdle;
      idx_q       <= '0;
      en_q        <= '0;
      seq_flt_q   <= '0;
      run_flt_q   <= '0;
      stable_q    <= 1'b0;
      dn_flt_q    <= 1'b0;
      pwr_ok_q    <= 1'b0;
    end else begin
      pg_meta_q   <= iPG;
      pg_sync_q   <= pg_meta_q;
      leak_meta_q <= iLeak_N;
      leak_sync_q <= leak_meta_q;
      state_q     <= state_d;
      idx_q       <= idx_d;
      en_q        <= en_d;
      seq_flt_q   <= seq_flt_d;
      run_flt_q   <= run_flt_d;
      stable_q    <= stable_d;
      dn_flt_q    <= dn_flt_d;
      pwr_ok_q    <= pwr_ok_d;
    end
  end

  assign oRail_EN = en_q;
  assign oSeqFlt  = seq_flt_q;
  assign oRunFlt  = run_flt_q;
  assign oState   = state_q;
  assign oPwr_Ok  = pwr_ok_q;

endmodule

// File: tb/tb_pwr_seq_nrail.sv
// Directed bench for pwr_seq_nrail (4 rails, default delays). One tick = 4 clocks.
module tb_pwr_seq_nrail;

  localparam int N = 4;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b1;
  logic         tick   = 1'b0;
  logic         req    = 1'b0;
  logic         leak_n = 1'b1;
  logic         fclr   = 1'b0;
  logic [N-1:0] mask   = '0;
  logic [N-1:0] pg     = '0;
  logic [N-1:0] en, seq_flt, run_flt;
  logic [3:0]   st;
  logic         pwr_ok;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwr_seq_nrail #(
    .NUM_RAILS (N)
  ) dut (
    .iClk       (clk),
    .iRst_n     (rst_n),
    .iTick_1ms  (tick),
    .iPwr_Req   (req),
    .iLeak_N    (leak_n),
    .iRail_Mask (mask),
    .iPG        (pg),
    .iFault_Clr (fclr),
    .oRail_EN   (en),
    .oSeqFlt    (seq_flt),
    .oRunFlt    (run_flt),
    .oState     (st),
    .oPwr_Ok    (pwr_ok)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 1 ms strobe: high for one clock, then three idle clocks
  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  // Unmasked rail i: PG rises 3 ticks after EN, then 10 stable ticks to the next step
  task automatic rail_up(input int i);
    logic [3:0] e;
    e = '0;
    for (int k = 0; k <= i; k++) e[k] = 1'b1;
    tick_n(3);
    pg[i] = 1'b1;
    clk_n(3);
    tick_n(9);
    chk($sformatf("r%0d_hold", i), en, e);
    tick_n(1);
    if (i < N - 1) begin
      e[i+1] = 1'b1;
      chk($sformatf("r%0d_step", i), en, e);
    end else begin
      chk("on_state", st, 4'h0);
      chk("on_pwrok", {3'b000, pwr_ok}, 4'h1);
    end
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_en", en, 4'h0);
    chk("rst_st", st, 4'h9);
    chk("rst_ok", {3'b000, pwr_ok}, 4'h0);
    chk("rst_sf", seq_flt, 4'h0);
    chk("rst_rf", run_flt, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clk_n(2);

    // T1: nominal up and down
    req = 1'b1;
    clk_n(1);
    chk("t1_en0", en, 4'b0001);
    chk("t1_st", st, 4'h1);
    for (int i = 0; i < N; i++) rail_up(i);
    req = 1'b0;
    clk_n(1);
    chk("t1_dn3", en, 4'b0111);
    chk("t1_dnst", st, 4'h2);
    chk("t1_okoff", {3'b000, pwr_ok}, 4'h0);
    tick_n(9);
    chk("t1_dn_hold", en, 4'b0111);
    tick_n(1);
    chk("t1_dn2", en, 4'b0011);
    tick_n(10);
    chk("t1_dn1", en, 4'b0001);
    tick_n(10);
    chk("t1_dn0", en, 4'b0000);
    tick_n(9);
    chk("t1_dn_wait", st, 4'h2);
    tick_n(1);
    chk("t1_idle", st, 4'h9);
    pg = '0;

    // T2: PG[2] never rises
    req = 1'b1;
    clk_n(1);
    rail_up(0);
    rail_up(1);
    tick_n(9999);
    chk("t2_pre_sf", seq_flt, 4'h0);
    chk("t2_pre_st", st, 4'h1);
    tick_n(1);
    chk("t2_sf", seq_flt, 4'b0100);
    chk("t2_en2", en, 4'b0011);
    chk("t2_st", st, 4'h2);
    tick_n(10);
    chk("t2_en1", en, 4'b0001);
    tick_n(10);
    chk("t2_en0", en, 4'b0000);
    tick_n(10);
    chk("t2_fault", st, 4'hF);
    fclr = 1'b1;
    clk_n(1);
    fclr = 1'b0;
    clk_n(1);
    chk("t2_clr_ign", st, 4'hF);
    chk("t2_sf_kept", seq_flt, 4'b0100);
    req = 1'b0;
    fclr = 1'b1;
    clk_n(1);
    fclr = 1'b0;
    clk_n(1);
    chk("t2_clr_st", st, 4'h9);
    chk("t2_clr_sf", seq_flt, 4'h0);
    pg = '0;

    // T3: runtime PG loss on rail 1
    req = 1'b1;
    clk_n(1);
    for (int i = 0; i < N; i++) rail_up(i);
    pg[1] = 1'b0;
    clk_n(3);
    pg[1] = 1'b1;
    chk("t3_rf", run_flt, 4'b0010);
    chk("t3_st", st, 4'h2);
    chk("t3_en", en, 4'b0111);
    tick_n(30);
    chk("t3_en_off", en, 4'b0000);
    tick_n(10);
    chk("t3_fault", st, 4'hF);
    req = 1'b0;
    fclr = 1'b1;
    clk_n(1);
    fclr = 1'b0;
    clk_n(1);
    chk("t3_clr_rf", run_flt, 4'h0);
    pg = '0;

    // T3b: same pulse on masked rail 1
    mask = 4'b0010;
    req = 1'b1;
    clk_n(1);
    rail_up(0);
    tick_n(9);
    chk("t3m_hold", en, 4'b0011);
    tick_n(1);
    chk("t3m_step", en, 4'b0111);
    rail_up(2);
    rail_up(3);
    pg[1] = 1'b1;
    clk_n(3);
    pg[1] = 1'b0;
    clk_n(3);
    pg[1] = 1'b1;
    clk_n(3);
    chk("t3m_st", st, 4'h0);
    chk("t3m_rf", run_flt, 4'h0);
    req = 1'b0;
    clk_n(1);
    tick_n(40);
    chk("t3m_idle", st, 4'h9);
    mask = '0;
    pg = '0;

    // T5: PG[0] glitch during its stable window
    req = 1'b1;
    clk_n(1);
    pg[0] = 1'b1;
    clk_n(3);
    tick_n(5);
    pg[0] = 1'b0;
    clk_n(3);
    tick_n(1);
    chk("t5_glitch_st", st, 4'h1);
    pg[0] = 1'b1;
    clk_n(3);
    tick_n(9);
    chk("t5_hold", en, 4'b0001);
    chk("t5_sf", seq_flt, 4'h0);
    tick_n(1);
    chk("t5_step", en, 4'b0011);

    // T4: leak during PWRUP of rail 2
    rail_up(1);
    leak_n = 1'b0;
    clk_n(3);
    chk("t4_en", en, 4'b0001);
    chk("t4_st", st, 4'hE);
    req = 1'b0;
    clk_n(2);
    chk("t4_req0", st, 4'hE);
    req = 1'b1;
    clk_n(2);
    chk("t4_req1_st", st, 4'hE);
    chk("t4_req1_en", en, 4'b0001);

    // T6: asynchronous reset in ON
    rst_n = 1'b0;
    clk_n(1);
    leak_n = 1'b1;
    pg = '0;
    req = 1'b0;
    rst_n = 1'b1;
    clk_n(3);
    chk("t6_idle", st, 4'h9);
    req = 1'b1;
    clk_n(1);
    for (int i = 0; i < N; i++) rail_up(i);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_en", en, 4'h0);
    chk("t6_st", st, 4'h9);
    chk("t6_ok", {3'b000, pwr_ok}, 4'h0);
    chk("t6_sf", seq_flt, 4'h0);
    chk("t6_rf", run_flt, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
